// File: rtl/parity_pkg.sv
// Shared types and constants for the parity serial transmitter.
package parity_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

endpackage

// File: rtl/parity_serial_tx_baud.sv
// Baud tick generator: o_tick is high on the last cycle of each serial bit.
// Counter is held at zero while i_clear is high so every frame starts aligned.
module parity_baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

   logic [15:0] r_cnt;

   assign o_tick = (r_cnt == TERM);

   // Count 0..CLKS_PER_BIT-1 and wrap; with one clock per bit it stays at 0.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/parity_serial_tx.sv
// Serialises a byte plus parity as start, 8 data bits LSB first, parity, stop.
// Optional feature macro: PARITY_SERIAL_TX_ERR_INJ_EN adds err_inj, which
// inverts the transmitted parity bit of the frame accepted with it high.
module parity_serial_tx
   import parity_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int ODD_PARITY   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
   input  logic       err_inj,
`endif
   input  logic [7:0] data_in,
   input  logic       parity_in,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       tx_out,
   output logic       tx_busy,
   output logic       frame_done
);

   tx_state_t   r_state;
   tx_state_t   w_next_state;
   logic [7:0]  r_shift;
   logic        r_parity;
   logic [2:0]  r_bit_idx;
   logic        r_stop_idx;
   logic        w_tick;
   logic        w_err;
   logic        w_accept;
   logic        w_last_stop;

`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
   assign w_err = err_inj;
`else
   assign w_err = 1'b0;
`endif

   assign w_accept    = (r_state == IDLE) && data_valid;
   assign w_last_stop = (r_stop_idx == 1'(STOP_BITS - 1));

   parity_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clear (r_state == IDLE),
      .o_tick  (w_tick)
   );

   // State register plus frame datapath (shift register, parity, bit counters).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_shift    <= data_in;
            r_parity   <= parity_in ^ (ODD_PARITY != 0) ^ w_err;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
         end else if (w_tick && (r_state == DATA)) begin
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 3'd1;
         end else if (w_tick && (r_state == STOP)) begin
            r_stop_idx <= r_stop_idx + 1'b1;
         end
      end
   end

   // Next-state decode and per-state line/handshake outputs.
   always_comb begin
      w_next_state = r_state;
      tx_out       = IDLE_LEVEL;
      data_ready   = 1'b0;
      tx_busy      = 1'b1;
      frame_done   = 1'b0;
      case (r_state)
         IDLE: begin
            data_ready = 1'b1;
            tx_busy    = 1'b0;
            if (data_valid) w_next_state = START;
         end
         START: begin
            tx_out = 1'b0;
            if (w_tick) w_next_state = DATA;
         end
         DATA: begin
            tx_out = r_shift[0];
            if (w_tick && (r_bit_idx == 3'(DATA_BITS - 1))) w_next_state = PARITY;
         end
         PARITY: begin
            tx_out = r_parity;
            if (w_tick) w_next_state = STOP;
         end
         STOP: begin
            tx_out = IDLE_LEVEL;
            if (w_tick && w_last_stop) begin
               frame_done   = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx: three configurations checked
// cycle by cycle against a frame model built from the line format rules.
module tb_parity_serial_tx;

`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din [3];
   logic       pin [3];
   logic       vin [3];
   logic       ein [3];
   logic [2:0] tx_w, rdy_w, busy_w, done_w;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   parity_serial_tx #(.CLKS_PER_BIT(4), .ODD_PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .reset(reset),
`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
      .err_inj(ein[0]),
`endif
      .data_in(din[0]), .parity_in(pin[0]), .data_valid(vin[0]),
      .data_ready(rdy_w[0]), .tx_out(tx_w[0]), .tx_busy(busy_w[0]), .frame_done(done_w[0]));

   parity_serial_tx #(.CLKS_PER_BIT(3), .ODD_PARITY(1), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset),
`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
      .err_inj(ein[1]),
`endif
      .data_in(din[1]), .parity_in(pin[1]), .data_valid(vin[1]),
      .data_ready(rdy_w[1]), .tx_out(tx_w[1]), .tx_busy(busy_w[1]), .frame_done(done_w[1]));

   parity_serial_tx #(.CLKS_PER_BIT(1), .ODD_PARITY(0), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset),
`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
      .err_inj(ein[2]),
`endif
      .data_in(din[2]), .parity_in(pin[2]), .data_valid(vin[2]),
      .data_ready(rdy_w[2]), .tx_out(tx_w[2]), .tx_busy(busy_w[2]), .frame_done(done_w[2]));

   function automatic int cpb(int i);
      if (i == 0) return 4;
      if (i == 1) return 3;
      return 1;
   endfunction

   function automatic logic odd(int i);
      return (i == 1);
   endfunction

   function automatic int stopb(int i);
      return (i == 2) ? 2 : 1;
   endfunction

   // Expected line level on cycle c (1-based) after the accept edge.
   function automatic logic exp_line(int i, logic [7:0] d, logic p, logic e, int c);
      int b;
      b = (c - 1) / cpb(i);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (b == 9) return p ^ odd(i) ^ e;
      return 1'b1;
   endfunction

   task automatic present(int i, logic [7:0] d, logic p, logic e);
      din[i] = d;
      pin[i] = p;
      ein[i] = e & ERR_EN;
      vin[i] = 1'b1;
   endtask

   task automatic check_idle(int i, string tag);
      logic [3:0] got;
      got = {tx_w[i], rdy_w[i], busy_w[i], done_w[i]};
      checks++;
      if (got !== 4'b1100) begin
         errors++;
         $display("FAIL %s inst%0d idle: tx/rdy/busy/done got %b want 1100", tag, i, got);
      end
   endtask

   // Called just after a negedge with the byte presented; accepts it on the
   // next posedge, checks every frame cycle, then the following idle cycle.
   task automatic check_frame(int i, string tag, logic [7:0] d, logic p, logic e,
                              bit keep, logic [7:0] nd, logic np, logic ne);
      int len;
      logic [3:0] got, want;
      len = (10 + stopb(i)) * cpb(i);
      @(posedge clk);
      #1;
      if (keep) begin
         present(i, nd, np, ne);
      end else begin
         vin[i] = 1'b0;
         din[i] = 8'($urandom);
         pin[i] = 1'($urandom);
         ein[i] = 1'($urandom) & ERR_EN;
      end
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         got  = {tx_w[i], rdy_w[i], busy_w[i], done_w[i]};
         want = {exp_line(i, d, p, e & ERR_EN, c), 1'b0, 1'b1, (c == len)};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: tx/rdy/busy/done got %b want %b",
                     tag, i, c, got, want);
         end
      end
      @(negedge clk);
      check_idle(i, tag);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         vin[i] = 1'b0; din[i] = '0; pin[i] = 1'b0; ein[i] = 1'b0;
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle(i, "reset");
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_even();
      present(0, 8'hA5, 1'b0, 1'b0);
      check_frame(0, "even_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_odd();
      present(1, 8'h07, 1'b1, 1'b0);
      check_frame(1, "odd_07", 8'h07, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      present(0, 8'h00, 1'b0, 1'b0);
      check_frame(0, "b2b_0", 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      check_frame(0, "b2b_1", 8'hFF, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
      check_frame(0, "b2b_2", 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      present(0, 8'h5A, 1'b0, 1'b0);
      @(posedge clk);
      #1 vin[0] = 1'b0;
      for (int c = 1; c <= 18; c++) @(negedge clk);
      checks++;
      if (tx_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_data_bit3 inst0: tx got %b want 1", tx_w[0]);
      end
      reset = 1'b1;
      @(negedge clk);
      check_idle(0, "reset_mid");
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_idle(0, "after_reset");
      end
      present(0, 8'hC3, 1'b0, 1'b0);
      check_frame(0, "fresh_c3", 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_cpb1_two_stop();
      present(2, 8'h81, 1'b0, 1'b0);
      check_frame(2, "cpb1_81", 8'h81, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
   task automatic test_err_inj();
      present(0, 8'hA5, 1'b0, 1'b1);
      check_frame(0, "errinj_on", 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      present(0, 8'hA5, 1'b0, 1'b0);
      check_frame(0, "errinj_off", 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask
`endif

   task automatic test_random();
      logic [7:0] d, nd;
      logic p, np, e, ne;
      bit keep;
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom); p = 1'($urandom); e = 1'($urandom);
         present(i, d, p, e);
         for (int k = 0; k < 5; k++) begin
            nd = 8'($urandom); np = 1'($urandom); ne = 1'($urandom);
            keep = (k < 4) && ($urandom_range(1) == 1);
            check_frame(i, "random", d, p, e, keep, nd, np, ne);
            if (!keep && k < 4) begin
               repeat ($urandom_range(3)) begin
                  @(negedge clk);
                  check_idle(i, "random_gap");
               end
               present(i, nd, np, ne);
            end
            d = nd; p = np; e = ne;
         end
      end
   endtask

   initial begin
      test_reset();
      test_even();
      test_odd();
      test_back_to_back();
      test_reset_mid_frame();
      test_cpb1_two_stop();
`ifdef PARITY_SERIAL_TX_ERR_INJ_EN
      test_err_inj();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
